// File: rtl/chirp_phase_generator.sv
// Linear-FM chirp phase generator: quadratic phase words streamed over AXI-Stream per chirp request.
// Optional macro CHIRP_ABORT_EN: chirp_enable low during ARM/RUN aborts the chirp into DONE.
module chirp_phase_generator #(
  parameter int ACC_W        = 32,
  parameter int PHASE_OUT_W  = 16,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   chirp_init,
  input  logic                   chirp_enable,
  input  logic [31:0]            chirp_len,
  input  logic [ACC_W-1:0]       chirp_freq_offset,
  input  logic [ACC_W-1:0]       chirp_tuning_word,
  output logic                   chirp_ready,
  output logic                   chirp_active,
  output logic                   chirp_done,
  output logic [PHASE_OUT_W-1:0] m_axis_phase_tdata,
  output logic                   m_axis_phase_tvalid,
  input  logic                   m_axis_phase_tready,
  output logic                   m_axis_phase_tlast
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_GUARD = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  phase_acc;
  logic [ACC_W-1:0]  freq_acc;
  logic [ACC_W-1:0]  step_reg;
  logic [31:0]       remaining;
  logic [GW-1:0]     guard_cnt;
  logic              beat;
  logic              last_beat;
  logic              abort;
  logic              unused_phase_bits;

`ifdef CHIRP_ABORT_EN
  assign abort = ~chirp_enable;
`else
  assign abort = 1'b0;
`endif

  assign beat      = (state == S_RUN) && m_axis_phase_tready;
  assign last_beat = (remaining == 32'd1);
  assign unused_phase_bits = ^phase_acc;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (chirp_init && chirp_enable) state_nxt = S_ARM;
      S_ARM:   if (abort || (chirp_len == 32'd0)) state_nxt = S_DONE;
               else state_nxt = S_RUN;
      S_RUN:   if (abort || (beat && last_beat)) state_nxt = S_DONE;
      S_DONE:  state_nxt = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
      S_GUARD: if (guard_cnt == GUARD_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode (Moore, straight from the state register)
  always_comb begin
    chirp_ready         = (state == S_IDLE);
    chirp_active        = (state == S_ARM) || (state == S_RUN);
    chirp_done          = (state == S_DONE);
    m_axis_phase_tvalid = (state == S_RUN);
    m_axis_phase_tlast  = (state == S_RUN) && last_beat;
    m_axis_phase_tdata  = phase_acc[ACC_W-1 -: PHASE_OUT_W];
  end

  // Accumulators: phase integrates frequency, frequency integrates the slope step
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_acc <= '0;
      freq_acc  <= '0;
      step_reg  <= '0;
      remaining <= '0;
    end else if (state == S_ARM) begin
      phase_acc <= '0;
      freq_acc  <= chirp_freq_offset;
      step_reg  <= chirp_tuning_word;
      remaining <= chirp_len;
    end else if (beat && !abort) begin
      phase_acc <= phase_acc + freq_acc;
      freq_acc  <= freq_acc + step_reg;
      remaining <= remaining - 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      guard_cnt <= '0;
    end else if (state == S_DONE) begin
      guard_cnt <= '0;
    end else if (state == S_GUARD) begin
      guard_cnt <= guard_cnt + 1'b1;
    end
  end

endmodule
